// File: rtl/dcfir_acc_dump.sv
`default_nettype none
// ============================================================================
// Module   : dcfir_acc_dump
// Purpose  : Complex accumulate-and-dump with shift, saturation and a 2-entry
//            output skid FIFO. Define DCFIR_ACC_ROUND_EN for round-half-up.
// Revision : 1.0
// ============================================================================
module dcfir_acc_dump #(
  parameter int ACC_W = 22
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               din_valid,
  input  logic signed [15:0] din_real,
  input  logic signed [15:0] din_imag,
  input  logic        [5:0]  acc_len,
  input  logic        [2:0]  shift,
  input  logic               dout_ready,
  output logic               dout_valid,
  output logic signed [15:0] dout_real,
  output logic signed [15:0] dout_imag,
  output logic               busy,
  output logic               sat_flag,
  output logic               ovf_flag
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-14){1'b0}}, 15'h7fff};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-14){1'b1}}, 15'h0000};
`ifdef DCFIR_ACC_ROUND_EN
  localparam logic signed [ACC_W:0] RND_ONE = {{ACC_W{1'b0}}, 1'b1};
`endif

  logic [0:0] state_q, state_d;

  logic        [6:0]       len_q, len_d;
  logic        [6:0]       cnt_q, cnt_d;
  logic        [2:0]       shift_q, shift_d;
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;

  // Dump stage register: holds a finished block sum for one cycle before the FIFO.
  logic                    dump_v_q, dump_v_d;
  logic signed [ACC_W-1:0] dump_r_q, dump_r_d;
  logic signed [ACC_W-1:0] dump_i_q, dump_i_d;
  logic        [2:0]       dump_sh_q, dump_sh_d;

  logic        [1:0]  fcnt_q, fcnt_d;
  logic signed [15:0] h_r_q, h_r_d, h_i_q, h_i_d;
  logic signed [15:0] t_r_q, t_r_d, t_i_q, t_i_d;
  logic               sat_q, sat_d;
  logic               ovf_q, ovf_d;

  logic signed [ACC_W-1:0] sext_r, sext_i;
  logic signed [ACC_W-1:0] sum_r, sum_i;
  logic        [6:0]       len_in;
  logic                    last_smp;
  logic        [16:0]      sc_r, sc_i;
  logic                    push, pop;

  function automatic logic [16:0] scale_sat(input logic signed [ACC_W-1:0] a,
                                            input logic        [2:0]       sh);
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] s;
    t = {a[ACC_W-1], a};
`ifdef DCFIR_ACC_ROUND_EN
    if (sh != 3'd0) t = t + (RND_ONE << (sh - 3'd1));
`endif
    s = t >>> sh;
    if (s > SAT_MAX)      scale_sat = {1'b1, 16'h7fff};
    else if (s < SAT_MIN) scale_sat = {1'b1, 16'h8000};
    else                  scale_sat = {1'b0, s[15:0]};
  endfunction

  assign sext_r   = {{(ACC_W-16){din_real[15]}}, din_real};
  assign sext_i   = {{(ACC_W-16){din_imag[15]}}, din_imag};
  assign sum_r    = acc_r_q + sext_r;
  assign sum_i    = acc_i_q + sext_i;
  assign len_in   = (acc_len == 6'd0) ? 7'd64 : {1'b0, acc_len};
  assign last_smp = ((cnt_q + 7'd1) == len_q);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (din_valid && (len_in != 7'd1)) state_d = S_ACC;
      S_ACC:   if (din_valid && last_smp)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q == S_ACC);
  end

  // ---------------- accumulator datapath ----------------
  always_comb begin
    len_d     = len_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    acc_r_d   = acc_r_q;
    acc_i_d   = acc_i_q;
    dump_v_d  = 1'b0;
    dump_r_d  = dump_r_q;
    dump_i_d  = dump_i_q;
    dump_sh_d = dump_sh_q;
    if (din_valid) begin
      if (state_q == S_IDLE) begin
        len_d   = len_in;
        shift_d = shift;
        acc_r_d = sext_r;
        acc_i_d = sext_i;
        cnt_d   = 7'd1;
        if (len_in == 7'd1) begin
          dump_v_d  = 1'b1;
          dump_r_d  = sext_r;
          dump_i_d  = sext_i;
          dump_sh_d = shift;
        end
      end else begin
        acc_r_d = sum_r;
        acc_i_d = sum_i;
        cnt_d   = cnt_q + 7'd1;
        if (last_smp) begin
          dump_v_d  = 1'b1;
          dump_r_d  = sum_r;
          dump_i_d  = sum_i;
          dump_sh_d = shift_q;
        end
      end
    end
  end

  // ---------------- scaling and output FIFO ----------------
  assign sc_r = scale_sat(dump_r_q, dump_sh_q);
  assign sc_i = scale_sat(dump_i_q, dump_sh_q);
  assign push = dump_v_q;
  assign pop  = (fcnt_q != 2'd0) && dout_ready;

  always_comb begin
    fcnt_d = fcnt_q;
    h_r_d  = h_r_q;
    h_i_d  = h_i_q;
    t_r_d  = t_r_q;
    t_i_d  = t_i_q;
    sat_d  = sat_q | (push & (sc_r[16] | sc_i[16]));
    ovf_d  = ovf_q;
    case (fcnt_q)
      2'd0: begin
        if (push) begin
          h_r_d  = sc_r[15:0];
          h_i_d  = sc_i[15:0];
          fcnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          h_r_d = sc_r[15:0];
          h_i_d = sc_i[15:0];
        end else if (push) begin
          t_r_d  = sc_r[15:0];
          t_i_d  = sc_i[15:0];
          fcnt_d = 2'd2;
        end else if (pop) begin
          fcnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          h_r_d = t_r_q;
          h_i_d = t_i_q;
          if (push) begin
            t_r_d = sc_r[15:0];
            t_i_d = sc_i[15:0];
          end else begin
            fcnt_d = 2'd1;
          end
        end else if (push) begin
          ovf_d = 1'b1;
        end
      end
      default: fcnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      acc_r_q   <= '0;
      acc_i_q   <= '0;
      dump_v_q  <= 1'b0;
      dump_r_q  <= '0;
      dump_i_q  <= '0;
      dump_sh_q <= '0;
      fcnt_q    <= '0;
      h_r_q     <= '0;
      h_i_q     <= '0;
      t_r_q     <= '0;
      t_i_q     <= '0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      acc_r_q   <= acc_r_d;
      acc_i_q   <= acc_i_d;
      dump_v_q  <= dump_v_d;
      dump_r_q  <= dump_r_d;
      dump_i_q  <= dump_i_d;
      dump_sh_q <= dump_sh_d;
      fcnt_q    <= fcnt_d;
      h_r_q     <= h_r_d;
      h_i_q     <= h_i_d;
      t_r_q     <= t_r_d;
      t_i_q     <= t_i_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
    end
  end

  assign dout_valid = (fcnt_q != 2'd0);
  assign dout_real  = h_r_q;
  assign dout_imag  = h_i_q;
  assign sat_flag   = sat_q;
  assign ovf_flag   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dcfir_acc_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcfir_acc_dump
// Purpose  : Self-checking bench for dcfir_acc_dump: queue-based reference
//            model compared every cycle, plus directed literal checks.
// Revision : 1.0
// ============================================================================
module tb_dcfir_acc_dump;

  logic               CLK;
  logic               rst;
  logic               din_valid;
  logic signed [15:0] din_real;
  logic signed [15:0] din_imag;
  logic        [5:0]  acc_len;
  logic        [2:0]  shift;
  logic               dout_ready;
  logic               dout_valid;
  logic signed [15:0] dout_real;
  logic signed [15:0] dout_imag;
  logic               busy;
  logic               sat_flag;
  logic               ovf_flag;

  dcfir_acc_dump #(.ACC_W(22)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .acc_len    (acc_len),
    .shift      (shift),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag),
    .busy       (busy),
    .sat_flag   (sat_flag),
    .ovf_flag   (ovf_flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: block sums in plain integers, FIFO as a bounded queue.
  int mq_r[$];
  int mq_i[$];
  int mlog_r[$];
  int mlog_i[$];
  bit started = 1'b0;
  bit in_blk, pend_v, pend_sat, m_sat, m_ovf, m_pop, sat_a, sat_b;
  int blen, bsh, sr, si, n, pend_r, pend_i;

  function automatic int scale(input int a, input int sh, output bit sat);
    int s;
`ifdef DCFIR_ACC_ROUND_EN
    s = (a + ((sh != 0) ? (1 << (sh - 1)) : 0)) >>> sh;
`else
    s = a >>> sh;
`endif
    sat = 1'b0;
    if (s > 32767)  begin s = 32767;  sat = 1'b1; end
    if (s < -32768) begin s = -32768; sat = 1'b1; end
    return s;
  endfunction

  always @(posedge CLK) begin
    started = 1'b1;
    if (rst) begin
      mq_r.delete(); mq_i.delete();
      in_blk = 0; pend_v = 0; pend_sat = 0; m_sat = 0; m_ovf = 0;
      n = 0; sr = 0; si = 0;
    end else begin
      m_pop = (mq_r.size() > 0) && dout_ready;
      if (pend_v) begin
        if (pend_sat) m_sat = 1'b1;
        if (mq_r.size() == 2 && !m_pop) m_ovf = 1'b1;
      end
      if (m_pop) begin
        void'(mq_r.pop_front());
        void'(mq_i.pop_front());
      end
      if (pend_v && mq_r.size() < 2) begin
        mq_r.push_back(pend_r); mq_i.push_back(pend_i);
        mlog_r.push_back(pend_r); mlog_i.push_back(pend_i);
      end
      pend_v = 1'b0;
      if (din_valid) begin
        if (!in_blk) begin
          blen = (acc_len == 6'd0) ? 64 : int'(acc_len);
          bsh  = int'(shift);
          sr   = int'(din_real);
          si   = int'(din_imag);
          n    = 1;
        end else begin
          sr += int'(din_real);
          si += int'(din_imag);
          n++;
        end
        if (n == blen) begin
          pend_r   = scale(sr, bsh, sat_a);
          pend_i   = scale(si, bsh, sat_b);
          pend_sat = sat_a | sat_b;
          pend_v   = 1'b1;
          in_blk   = 1'b0;
        end else begin
          in_blk = 1'b1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      check("dout_valid", dout_valid, mq_r.size() > 0);
      if (mq_r.size() > 0) begin
        check("dout_real", dout_real, mq_r[0]);
        check("dout_imag", dout_imag, mq_i[0]);
      end
      check("busy", busy, in_blk);
      check("sat_flag", sat_flag, m_sat);
      check("ovf_flag", ovf_flag, m_ovf);
    end
  end

  task automatic cyc(input bit v, input int r, input int i);
    @(negedge CLK);
    din_valid = v;
    din_real  = 16'(r);
    din_imag  = 16'(i);
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 0, 0);
  endtask

  function automatic int last_r();
    return (mlog_r.size() > 0) ? mlog_r[mlog_r.size()-1] : -99999;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din_valid = 1'b0; din_real = '0; din_imag = '0;
    acc_len = 6'd4; shift = 3'd0; dout_ready = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_real", dout_real, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {sat_flag, ovf_flag}, 0);
    rst = 1'b0;

    // Basic sum
    cyc(1, 100, 1); cyc(1, 200, 1);
    check("basic_busy", busy, 1);
    cyc(1, -50, 1); cyc(1, 7, 1);
    cyc(0, 0, 0);
    check("basic_early_valid", dout_valid, 0);
    check("basic_busy_end", busy, 0);
    cyc(0, 0, 0);
    check("basic_valid", dout_valid, 1);
    check("basic_real", dout_real, 257);
    check("basic_imag", dout_imag, 4);
    check("basic_model", last_r(), 257);
    idle(2);

    // Shift and round
    acc_len = 6'd2; shift = 3'd2;
    cyc(1, 3, 0); cyc(1, 2, 0); idle(4);
    check("round_a", last_r(), 1);
    cyc(1, 3, 0); cyc(1, 3, 0); idle(4);
`ifdef DCFIR_ACC_ROUND_EN
    check("round_b", last_r(), 2);
`else
    check("round_b", last_r(), 1);
`endif

    // Throughput with L==1
    acc_len = 6'd1; shift = 3'd0; mlog_r.delete();
    cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 3, 0); cyc(1, 4, 0); idle(4);
    check("thru_count", mlog_r.size(), 4);
    check("thru_ovf", ovf_flag, 0);

    // Saturation
    acc_len = 6'd0; shift = 3'd0; mlog_r.delete(); mlog_i.delete();
    repeat (64) cyc(1, 32767, -32768);
    idle(4);
    check("sat_count", mlog_r.size(), 1);
    check("sat_real", last_r(), 32767);
    check("sat_imag", (mlog_i.size() > 0) ? mlog_i[0] : 0, -32768);
    check("sat_flag_lit", sat_flag, 1);

    // Backpressure and overflow
    dout_ready = 1'b0; acc_len = 6'd1; mlog_r.delete();
    cyc(1, 10, 0); cyc(1, 20, 0); cyc(1, 30, 0); idle(3);
    check("bp_valid", dout_valid, 1);
    check("bp_head", dout_real, 10);
    check("bp_ovf", ovf_flag, 1);
    check("bp_model_n", mlog_r.size(), 2);
    dout_ready = 1'b1;
    @(negedge CLK);
    check("bp_second", dout_real, 20);
    @(negedge CLK);
    check("bp_empty", dout_valid, 0);

    // Mid-block reset then length change
    acc_len = 6'd8;
    cyc(1, 1, 1); cyc(1, 1, 1); cyc(1, 1, 1);
    @(negedge CLK);
    check("mid_busy", busy, 1);
    rst = 1'b1; din_valid = 1'b1; din_real = 16'sd99;
    @(negedge CLK);
    rst = 1'b0; din_valid = 1'b0; din_real = '0;
    check("rst2_flags", {sat_flag, ovf_flag, busy, dout_valid}, 0);
    mlog_r.delete();
    acc_len = 6'd2;
    cyc(1, 5, 0); cyc(1, 6, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    check("mid_valid", dout_valid, 1);
    check("mid_real", dout_real, 11);
    idle(3);
    check("mid_count", mlog_r.size(), 1);

    // Gapped input
    acc_len = 6'd3;
    cyc(1, 1, 0); idle(2); cyc(1, 2, 0); idle(2); cyc(1, 3, 0);
    cyc(0, 0, 0);
    check("gap_early", dout_valid, 0);
    cyc(0, 0, 0);
    check("gap_valid", dout_valid, 1);
    check("gap_real", dout_real, 6);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcfir_acc_dump.md
# dcfir_acc_dump

Complex accumulate-and-dump stage that sits directly downstream of the D-CFIR vector-matrix stage (`dcfir_vmm3`). It consumes that stage's 16-bit real/imag output stream and sums a programmable number of consecutive samples. It then scales each sum by a right shift, saturates it, and presents the result on a valid/ready output through a 2-entry skid FIFO. This gives the beamformer a decimated, back-pressurable sample stream.

## Interface
- `ACC_W`, default 22: accumulator width; must be ≥ 16+6.
- `CLK`, in, 1: clock; all logic on posedge.
- `rst`, in, 1: reset; **one clock; reset is synchronous and active-high**.
- `din_valid`, in, 1: input sample qualifier; no backpressure to upstream.
- `din_real`, in, 16: signed two's-complement real sample.
- `din_imag`, in, 16: signed two's-complement imag sample.
- `acc_len`, in, 6: samples per dump; 0 means 64.
- `shift`, in, 3: arithmetic right shift applied at dump (0–7).
- `dout_ready`, in, 1: downstream accepts `dout_*` when high with `dout_valid`.
- `dout_valid`, out, 1: output word valid.
- `dout_real`, out, 16: signed scaled and saturated real sum.
- `dout_imag`, out, 16: signed scaled and saturated imag sum.
- `busy`, out, 1: high while a block is partially accumulated.
- `sat_flag`, out, 1: sticky; set when any dump saturates.
- `ovf_flag`, out, 1: sticky; set when a dump is dropped because the FIFO is full.

## Operation
- The state machine has two states, IDLE and ACC.
- **IDLE**: on `din_valid`:
  - latch `L = (acc_len==0) ? 64 : acc_len` and `shift`;
  - load `acc_r`/`acc_i` with the sign-extended sample;
  - set `cnt = 1`;
  - go to ACC, or dump immediately if `L==1` and stay in IDLE.
- **ACC**: on each `din_valid`, `acc += sext(din)` and `cnt++`.
  - When the accepted sample makes `cnt==L`, the block dumps and the state returns to IDLE.
  - Cycles with `din_valid` low hold all state.
- **Dump value**: `s = (acc_final) >>> shift`, computed at ACC_W bits.
  - If `s` is outside [-32768, 32767], clamp it to the nearest bound and set `sat_flag`.
  - Real and imag are clamped independently; either one saturating sets the flag.
- `acc_len` and `shift` changes take effect only at the next block start. A block in progress uses its latched values.
- **Output FIFO** (2 entries):
  - A dump pushes one word.
  - A pop occurs when `dout_valid & dout_ready`.
  - Push and pop in the same cycle are both performed, with the occupancy unchanged.
  - A push into a full FIFO with no pop that cycle drops the new word, leaves the FIFO unchanged and sets `ovf_flag`.
- `dout_*` is driven from the FIFO head. The data stays stable while `dout_valid & ~dout_ready`.
- `busy` equals `state==ACC`.
- Reset values:
  - `dout_valid=0`, `dout_real=0`, `dout_imag=0`;
  - `busy=0`, `sat_flag=0`, `ovf_flag=0`;
  - FIFO empty, accumulators and counter 0, state IDLE.
- `sat_flag` and `ovf_flag` clear only on `rst`.

## Timing
- Latency: a last sample accepted at edge t into an empty FIFO gives `dout_valid=1` after edge t+1, holding the scaled sum.
- When the FIFO is non-empty, a new word appears behind the head in order; there is no reordering.
- Throughput: with `L==1`, one dump per cycle is sustained when `dout_ready` is held high.
- `rst` asserted mid-block or with a full FIFO:
  - all state clears at that edge;
  - the partial sum and the buffered words are discarded;
  - `din_valid` in the reset cycle is ignored.
- Combinational paths: none from `din_*` to `dout_*`. `dout_valid` is a register output and does not depend combinationally on `dout_ready`.

## Configuration
- `DCFIR_ACC_ROUND_EN` defined:
  - dump uses round-half-up, `s = (acc + (shift ? 1<<(shift-1) : 0)) >>>` shift;
  - the addition is performed at ACC_W+1 bits, then saturation is applied.
- `DCFIR_ACC_ROUND_EN` undefined: plain arithmetic-shift truncation (floor).

## Test plan
- **Basic sum**: `acc_len=4`, `shift=0`, real inputs 100, 200, -50, 7 and imag inputs 1, 1, 1, 1 on consecutive cycles, `dout_ready=1` -> one word real=257, imag=4, valid one cycle after the 4th sample; `busy` high for cycles 1–3.
- **Shift and round**: `acc_len=2`, `shift=2`, real 3, 2 -> 1 without the macro, 1 with the macro (5/4=1.25). Real 3, 3 -> 1 without, 2 with (6/4=1.5).
- **Saturation**: `acc_len=0` (64), `shift=0`, constant real 32767 and imag -32768 -> real 32767, imag -32768, `sat_flag=1`.
- **Backpressure and overflow**: `acc_len=1`, `dout_ready=0`, three valid samples 10, 20, 30:
  - FIFO holds 10, 20 and `dout` stays at 10;
  - `ovf_flag=1`;
  - raising `dout_ready` yields 10 then 20, then `dout_valid=0`.
- **Mid-block reset and length change**: `acc_len=8`, 3 samples, then `rst` for 1 cycle. Then `acc_len=2` with samples 5, 6 -> single output 11; the partial sum before reset never appears.
- **Gapped input**: `acc_len=3`, samples 1, 2, 3 separated by 2-cycle `din_valid` gaps -> output 6, one cycle after sample 3.
